// File: rtl/stopwatch_pkg.sv
// Shared types, constants and the BCD increment helper for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next two-digit BCD value; carry flags the 99 -> 00 wrap.
    typedef struct packed {
        logic       carry;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    // Digits at or above BCD_MAX roll over, so an out-of-range value can never persist.
    function automatic bcd_pair_t bcd_inc(input logic [3:0] tens, input logic [3:0] units);
        bcd_pair_t r;
        r.carry = 1'b0;
        r.tens  = tens;
        r.units = units + 4'd1;
        if (units >= BCD_MAX) begin
            r.units = 4'd0;
            if (tens >= BCD_MAX) begin
                r.tens  = 4'd0;
                r.carry = 1'b1;
            end else begin
                r.tens = tens + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge event pulse.
module btn_conditioner #(
    parameter int unsigned DEB_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic ev
);

    localparam logic [15:0] DEB_LIM = 16'(DEB_CYCLES);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        acc_q, acc_d;
    logic        ev_q, ev_d;
    logic [15:0] cnt_q, cnt_d;

    // Accept a new level only after it has stayed put long enough; any return to the
    // accepted level restarts the count. Only a rising accepted level raises an event.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        acc_d   = acc_q;
        cnt_d   = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == DEB_LIM) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        ev_d = acc_d & ~acc_q;
    end

    // Conditioner state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            ev_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ev = ev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button events, run/pause/lap FSM, tick prescaler, live and display count.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1200000,
    parameter int unsigned DEB_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       lap_btn,
    input  logic       inc_btn,
    output logic [3:0] disp_units,
    output logic [3:0] disp_tens,
    output logic       running,
    output logic       lap_active,
    output logic       tick
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 32'd1);

    logic ev_start, ev_stop, ev_lap, ev_inc;

    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk(clk), .rst(rst), .btn_in(start_btn), .ev(ev_start));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
        .clk(clk), .rst(rst), .btn_in(stop_btn), .ev(ev_stop));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk(clk), .rst(rst), .btn_in(lap_btn), .ev(ev_lap));
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .btn_in(inc_btn), .ev(ev_inc));

    sw_state_t   state_q, state_d;
    logic [3:0]  live_units_q, live_units_d;
    logic [3:0]  live_tens_q, live_tens_d;
    logic [3:0]  disp_units_q, disp_units_d;
    logic [3:0]  disp_tens_q, disp_tens_d;
    logic [31:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic        lap_q, lap_d;

    logic        counting, next_counting;
    logic        p_stop, p_start, p_lap, p_inc;
    logic        do_inc, do_clr;
    bcd_pair_t   nxt;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (presc_q == TICK_LAST);
    assign nxt      = bcd_inc(live_tens_q, live_units_q);

    // Resolve simultaneous events: stop beats start beats lap; inc only when nothing else fired.
    always_comb begin
        p_stop  = ev_stop;
        p_start = ev_start & ~ev_stop;
        p_lap   = ev_lap & ~ev_stop & ~ev_start;
        p_inc   = ev_inc & ~ev_stop & ~ev_start & ~ev_lap;
    end

    // Next-state and count-action decode; ticks still count on the cycle a transition leaves RUN/LAP.
    always_comb begin
        state_d = state_q;
        do_inc  = 1'b0;
        do_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (p_start)    state_d = ST_RUN;
                else if (p_inc) do_inc  = 1'b1;
            end
            ST_RUN: begin
                if (p_stop)     state_d = ST_PAUSE;
                else if (p_lap) state_d = ST_LAP;
                if (tick)       do_inc  = 1'b1;
            end
            ST_LAP: begin
                if (p_stop)     state_d = ST_PAUSE;
                else if (p_lap) state_d = ST_RUN;
                if (tick)       do_inc  = 1'b1;
            end
            ST_PAUSE: begin
                if (p_stop) begin
                    state_d = ST_IDLE;
                    do_clr  = 1'b1;
                end else if (p_start) begin
                    state_d = ST_RUN;
                end else if (p_inc) begin
                    do_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Live count, frozen display (only while staying in LAP), prescaler and registered flags.
    always_comb begin
        live_units_d = live_units_q;
        live_tens_d  = live_tens_q;
        if (do_clr) begin
            live_units_d = 4'd0;
            live_tens_d  = 4'd0;
        end else if (do_inc) begin
            live_units_d = nxt.units;
            live_tens_d  = nxt.carry ? 4'd0 : nxt.tens;
        end

        if ((state_q == ST_LAP) && (state_d == ST_LAP)) begin
            disp_units_d = disp_units_q;
            disp_tens_d  = disp_tens_q;
        end else begin
            disp_units_d = live_units_d;
            disp_tens_d  = live_tens_d;
        end

        // Free-runs across LAP<->RUN; any entry from IDLE/PAUSE starts from 0.
        next_counting = (state_d == ST_RUN) || (state_d == ST_LAP);
        if (counting && next_counting) begin
            presc_d = (presc_q == TICK_LAST) ? 32'd0 : presc_q + 32'd1;
        end else begin
            presc_d = 32'd0;
        end

        running_d = next_counting;
        lap_d     = (state_d == ST_LAP);
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            live_units_q <= 4'd0;
            live_tens_q  <= 4'd0;
            disp_units_q <= 4'd0;
            disp_tens_q  <= 4'd0;
            presc_q      <= 32'd0;
            running_q    <= 1'b0;
            lap_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_units_q <= live_units_d;
            live_tens_q  <= live_tens_d;
            disp_units_q <= disp_units_d;
            disp_tens_q  <= disp_tens_d;
            presc_q      <= presc_d;
            running_q    <= running_d;
            lap_q        <= lap_d;
        end
    end

    assign disp_units = disp_units_q;
    assign disp_tens  = disp_tens_q;
    assign running    = running_q;
    assign lap_active = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEB_CYCLES=4.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] disp_units, disp_tens;
    logic       running, lap_active, tick;
    logic [7:0] disp;
    logic [7:0] live;

    int total = 0;
    int bad = 0;
    int ev_start_cnt = 0;
    int lap_cnt = 0;

    stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .start_btn(start_btn), .stop_btn(stop_btn), .lap_btn(lap_btn), .inc_btn(inc_btn),
        .disp_units(disp_units), .disp_tens(disp_tens),
        .running(running), .lap_active(lap_active), .tick(tick));

    always #5 clk = ~clk;

    assign disp = {disp_tens, disp_units};
    assign live = {dut.live_tens_q, dut.live_units_q};

    always @(negedge clk) begin
        if (dut.ev_start) ev_start_cnt <= ev_start_cnt + 1;
        if (lap_active)   lap_cnt      <= lap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: start_btn = v;
            1: stop_btn  = v;
            2: lap_btn   = v;
            default: inc_btn = v;
        endcase
    endtask

    // Clean press: held long enough to be accepted, then released and let settle.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (8) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    // Returns on the negedge where the n-th tick is seen high.
    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < n * TD * 2 + 20) begin
            @(negedge clk);
            cyc++;
            if (tick) seen++;
        end
        if (seen < n) chk("tick timeout", seen, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int run_cyc;
        int tk;
        int gap;
        int lap_base;

        // Reset with a button held
        rst = 1'b1;
        start_btn = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst disp", disp, 8'h00);
        chk("rst running", running, 0);
        chk("rst lap", lap_active, 0);
        chk("rst tick", tick, 0);
        rst = 1'b0;
        start_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("post rst idle", {running, lap_active, tick}, 0);
        chk("post rst no ev", ev_start_cnt, 0);

        // Bounce on start, then a clean final rise
        for (int i = 0; i < 3; i++) begin
            start_btn = 1'b1;
            repeat (2) @(negedge clk);
            start_btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        start_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (running) lat = k;
        end
        chk("bounce latency", lat, 8);
        chk("bounce ev count", ev_start_cnt, 1);
        start_btn = 1'b0;

        // Run to 95, lap, live wraps to 03, lap back with stop one cycle behind
        wait_ticks(95);
        lap_btn = 1'b1;
        @(negedge clk);
        chk("run 95", disp, 8'h95);
        repeat (7) @(negedge clk);
        chk("lap entry", {running, lap_active}, 2'b11);
        chk("lap disp", disp, 8'h95);
        lap_btn = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        chk("lap live 99", live, 8'h99);
        chk("lap hold", disp, 8'h95);
        wait_ticks(4);
        lap_btn = 1'b1;
        @(negedge clk);
        chk("lap live 03", live, 8'h03);
        chk("lap hold 2", disp, 8'h95);
        stop_btn = 1'b1;
        repeat (7) @(negedge clk);
        chk("lap exit disp", disp, 8'h03);
        chk("lap exit flags", {running, lap_active}, 2'b10);
        @(negedge clk);
        chk("stop disp", disp, 8'h03);
        chk("stop running", running, 0);
        lap_btn = 1'b0;
        stop_btn = 1'b0;
        repeat (10) @(negedge clk);

        // Pause: inc to 09 then carry to 10, then clear
        repeat (6) press(3);
        chk("pause inc 09", disp, 8'h09);
        press(3);
        chk("pause inc carry", disp, 8'h10);
        press(1);
        chk("clear disp", disp, 8'h00);
        chk("clear idle", {running, lap_active}, 0);

        // Start from IDLE: first tick in the 10th RUN cycle, then every 10
        start_btn = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (running) lat = k;
        end
        chk("start latency", lat, 8);
        start_btn = 1'b0;
        run_cyc = 1;
        tk = 0;
        while (tk == 0 && run_cyc < 40) begin
            @(negedge clk);
            run_cyc++;
            if (tick) tk = run_cyc;
        end
        chk("first tick cycle", tk, 10);
        @(negedge clk);
        chk("first tick disp", disp, 8'h01);
        chk("no back-to-back tick", tick, 0);
        gap = 1;
        while (gap < 40) begin
            @(negedge clk);
            gap++;
            if (tick) break;
        end
        chk("tick spacing", gap, 10);

        // Priority: start+stop+lap together in RUN
        lap_base = lap_cnt;
        start_btn = 1'b1;
        stop_btn = 1'b1;
        lap_btn = 1'b1;
        repeat (8) @(negedge clk);
        chk("prio running", running, 0);
        chk("prio disp", disp, 8'h02);
        chk("prio lap dropped", lap_cnt - lap_base, 0);
        start_btn = 1'b0;
        stop_btn = 1'b0;
        lap_btn = 1'b0;
        repeat (10) @(negedge clk);

        // Resume, inc ignored in RUN, count to 42, reset mid-run
        start_btn = 1'b1;
        repeat (8) @(negedge clk);
        chk("resume run", running, 1);
        start_btn = 1'b0;
        inc_btn = 1'b1;
        repeat (8) @(negedge clk);
        chk("inc ignored", disp, 8'h02);
        inc_btn = 1'b0;
        wait_ticks(40);
        @(negedge clk);
        chk("run 42", disp, 8'h42);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst disp", disp, 8'h00);
        chk("mid rst idle", {running, lap_active, tick}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("after rst idle", {running, disp}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the two-digit BCD seconds counter and its seven-segment digit drivers. It debounces the start/stop/lap/inc buttons and runs a four-state run/pause/lap FSM. A single-clock tick enable replaces the derived divided clock, and the controller owns the live count and the frozen display value. It sits between the raw button pins and the existing seven-segment decoder; `disp_units` and `disp_tens` connect directly to the decoder's digit inputs.

## Interface
- `TICK_DIV`, default 1200000: clk cycles per count tick; legal range 2..2^32-1.
- `DEB_CYCLES`, default 65535: cycles a synchronized button level must be stable before it is accepted; legal range 1..2^16-1.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_btn` in 1: raw, asynchronous, active-high.
- `stop_btn` in 1: raw, asynchronous, active-high.
- `lap_btn` in 1: raw, asynchronous, active-high.
- `inc_btn` in 1: raw, asynchronous, active-high.
- `disp_units` out 4: BCD units digit shown on the display.
- `disp_tens` out 4: BCD tens digit shown on the display.
- `running` out 1: high in RUN and LAP.
- `lap_active` out 1: high in LAP.
- `tick` out 1: one-cycle pulse, asserted every `TICK_DIV` cycles while counting.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchronizer, then a stability counter. After the counter accepts a new level, a rising edge of the accepted level produces a one-cycle event: `ev_start`, `ev_stop`, `ev_lap`, `ev_inc`. Release produces no event.
- **Live count:** internal registers `live_units` and `live_tens`, each 0..9.
  - Increment: units 9→0 carries into tens; 99→00 wraps silently.
  - Digits never leave the range 0..9.
- **States:** IDLE, RUN, PAUSE, LAP. Reset state is IDLE.
- **IDLE:**
  - `ev_start` → RUN.
  - `ev_inc` → increment the count, stay in IDLE.
- **RUN:**
  - `ev_stop` → PAUSE.
  - `ev_lap` → LAP.
  - `tick` → increment the count.
- **LAP:**
  - The live count keeps incrementing on `tick`; the display holds the value captured on entry to LAP.
  - `ev_lap` → RUN; the display reloads the live value.
  - `ev_stop` → PAUSE; the display reloads the live value.
- **PAUSE:**
  - `ev_start` → RUN.
  - `ev_stop` → IDLE and clear the count to 00.
  - `ev_inc` → increment the count.
- **Priority of simultaneous events:** stop > start > lap. Lower-priority events in the same cycle are dropped.
- `ev_inc` is ignored in RUN and LAP.
- **Prescaler:** counts 0..`TICK_DIV`-1 only in RUN and LAP.
  - `tick` asserts when the prescaler is at `TICK_DIV`-1.
  - The prescaler clears on every transition into RUN from IDLE or PAUSE, and holds at 0 in IDLE and PAUSE.
  - It does not clear on LAP↔RUN transitions.
- If a tick and an FSM transition fall in the same cycle: RUN+`ev_stop` still applies the tick's increment; LAP+`ev_lap` applies the increment and the display shows the incremented value.

## Timing
- **Reset values:** every output is 0. All registers are cleared: state IDLE, live count 00, prescaler 0, synchronizers 0, stability counters 0, accepted levels 0.
- **Reset mid-operation:** `rst` overrides every other input in the same cycle. Events in flight are discarded.
- **Button latency:** the event pulse appears 2 + `DEB_CYCLES` + 1 cycles after a clean button rise.
- **Bounce rejection:** any level change before the stability counter completes restarts the counter. A pulse shorter than `DEB_CYCLES` never produces an event.
- **Event to output:** the FSM state, `running`, `lap_active`, live count and display all update on the edge after the event cycle.
- **Tick to display:** the count register updates on the edge that samples `tick`=1. The display equals the live count in that same cycle, so there is no extra latency outside LAP.
- **First tick:** the first `tick` after entering RUN asserts `TICK_DIV` cycles after the state change; later ticks are every `TICK_DIV` cycles.
- **Tick spacing:** `tick` is never asserted in two consecutive cycles.

## Structure
- Shared package `stopwatch_pkg` holds:
  - the state encoding `sw_state_t` (IDLE=0, RUN=1, PAUSE=2, LAP=3);
  - the constant `BCD_MAX`=9;
  - the BCD increment function, which returns the next digit pair plus the carry.
- Sub-module `btn_conditioner` (synchronizer, stability counter and edge pulse; parameter `DEB_CYCLES`) is instantiated four times.
- Prescaler, FSM and count/display registers live in the top level.

## Test plan
Scenarios use `TICK_DIV`=10 and `DEB_CYCLES`=4.
- **Reset:** assert `rst` for 3 cycles → all outputs are 0 and the state is IDLE, even when a button was held during reset.
- **Bounce:** `start_btn` toggles every 2 cycles for 12 cycles, then stays high → exactly one `ev_start`; `running`=1 occurs 8 cycles after the final rise.
- **Run, lap, release, stop:**
  - Start, then wait 95 ticks → display 95.
  - Lap → display holds 95 while the live count reaches 99, then wraps to 00 and on to 03.
  - Lap again → display 03.
  - Stop → display 03; `running`=0.
- **Pause inc and clear:**
  - From PAUSE at 09, an inc press → 10.
  - A second stop → IDLE with display 00.
  - Start → the first `tick` arrives exactly 10 cycles later.
- **Priority:** `start_btn`, `stop_btn` and `lap_btn` raised together in RUN → PAUSE; the lap event is dropped and `lap_active` stays 0.
- **Inc ignored and mid-run reset:** an inc press in RUN → no extra increment. Then assert `rst` mid-count at 42 → display 00 and IDLE on the next cycle.
